// File: rtl/display_arb_pkg.sv
// Shared definitions for the display-share arbiter: requester count,
// FSM state encoding and default minimum hold time.
package display_arb_pkg;

   localparam int NREQ            = 4;
   localparam int DEF_HOLD_CYCLES = 5000000;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_OWN  = 1'b1;

   typedef enum logic {
      IDLE = ST_IDLE,
      OWN  = ST_OWN
   } state_t;

   function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
      logic [NREQ-1:0] r;
      r      = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin picker: first set request strictly after ptr, wrapping,
// with ptr itself considered last unless excluded.
module rr_next_sel
   import display_arb_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      ptr,
   input  logic            excludeOwner,
   output logic            valid,
   output logic [1:0]      sel
);

   logic [NREQ-1:0] cand;
   logic [1:0]      idx;

   // Scan from the farthest position down so the nearest candidate wins.
   always_comb begin
      cand = req;
      if (excludeOwner) cand[ptr] = 1'b0;
      valid = 1'b0;
      sel   = ptr;
      idx   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = ptr + 2'(k);
         if (cand[idx]) begin
            valid = 1'b1;
            sel   = idx;
         end
      end
   end

endmodule

// File: rtl/display_share_arbiter.sv
// Time-shares the 4-digit display path between four requesters with
// round-robin grants and a minimum hold time per owner.
module display_share_arbiter #(
   parameter int HOLD_CYCLES = 5000000,
   parameter int NREQ        = 4
) (
   input  logic              clk5,
   input  logic              resetn,
   input  logic [NREQ-1:0]   req,
   input  logic [16*NREQ-1:0] reqVal,
   input  logic [4*NREQ-1:0] reqPoint,
   output logic [NREQ-1:0]   grant,
   output logic [15:0]       dispVal,
   output logic [3:0]        point,
   output logic              busy
);
   import display_arb_pkg::*;

   localparam int             CW       = $clog2(HOLD_CYCLES);
   localparam logic [CW-1:0]  HOLD_MAX = CW'(HOLD_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] holdCnt;
   logic [1:0]    ptr;

   logic          nxtValid;
   logic [1:0]    nxtSel;
   logic          load;
   logic          goIdle;
   logic          active;
   logic [1:0]    outSel;

   rr_next_sel u_rr (
      .req          (req),
      .ptr          (ptr),
      .excludeOwner (state == OWN),
      .valid        (nxtValid),
      .sel          (nxtSel)
   );

   // load: a new owner takes the display this edge; goIdle: owner released
   // with nobody waiting.
   always_comb begin
      load   = 1'b0;
      goIdle = 1'b0;
      case (state)
         IDLE: load = nxtValid;
         OWN: begin
            if (!req[ptr]) begin
               load   = nxtValid;
               goIdle = !nxtValid;
            end else if (holdCnt == HOLD_MAX) begin
               load = nxtValid;
            end
         end
         default: ;
      endcase
      active = load || (state == OWN && !goIdle);
      outSel = load ? nxtSel : ptr;
   end

   always_ff @(posedge clk5 or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         holdCnt <= '0;
         ptr     <= 2'd3;
         grant   <= '0;
         dispVal <= 16'h0000;
         point   <= 4'b0000;
         busy    <= 1'b0;
      end else begin
         if (load) begin
            state   <= OWN;
            holdCnt <= '0;
            ptr     <= nxtSel;
            grant   <= onehot(nxtSel);
         end else if (goIdle) begin
            state   <= IDLE;
            grant   <= '0;
         end else if (state == OWN && holdCnt != HOLD_MAX) begin
            holdCnt <= holdCnt + 1'b1;
         end
         busy <= active;
         if (active) begin
            dispVal <= reqVal[{outSel, 4'b0000} +: 16];
            point   <= reqPoint[{outSel, 2'b00} +: 4];
         end else begin
            dispVal <= 16'h0000;
            point   <= 4'b0000;
         end
      end
   end

endmodule

// File: tb/tb_display_share_arbiter.sv
// Bench for display_share_arbiter with a 4-cycle hold: per-cycle vector table
// feeding a scoreboard, plus directed datapath and async-reset sequences.
module tb_display_share_arbiter;

   localparam int HOLD = 4;

   logic        clk5 = 1'b0;
   logic        resetn = 1'b0;
   logic [3:0]  req = '0;
   logic [63:0] reqVal;
   logic [15:0] reqPoint;
   logic [3:0]  grant;
   logic [15:0] dispVal;
   logic [3:0]  point;
   logic        busy;

   always #5 clk5 = ~clk5;

   display_share_arbiter #(.HOLD_CYCLES(HOLD), .NREQ(4)) dut (
      .clk5     (clk5),
      .resetn   (resetn),
      .req      (req),
      .reqVal   (reqVal),
      .reqPoint (reqPoint),
      .grant    (grant),
      .dispVal  (dispVal),
      .point    (point),
      .busy     (busy)
   );

   typedef struct {
      logic [3:0] req;
      logic [3:0] grant;
   } vec_t;

   typedef struct {
      logic [3:0]  grant;
      logic [15:0] disp;
      logic [3:0]  point;
      logic        busy;
      int          idx;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] r, input int n, input logic [3:0] g);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.req   = r;
         v.grant = g;
         vecs.push_back(v);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] g, input int idx);
      exp_t e;
      e.grant = g;
      e.busy  = (g != 4'b0000);
      e.disp  = 16'h0000;
      e.point = 4'b0000;
      e.idx   = idx;
      for (int i = 0; i < 4; i++)
         if (g[i]) begin
            e.disp  = reqVal[16*i +: 16];
            e.point = reqPoint[4*i +: 4];
         end
      return e;
   endfunction

   task automatic check_out(input exp_t e);
      chk($sformatf("grant[%0d]", e.idx), 32'(grant), 32'(e.grant));
      chk($sformatf("dispVal[%0d]", e.idx), 32'(dispVal), 32'(e.disp));
      chk($sformatf("point[%0d]", e.idx), 32'(point), 32'(e.point));
      chk($sformatf("busy[%0d]", e.idx), 32'(busy), 32'(e.busy));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      reqVal   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      reqPoint = 16'h35AC;

      // first grant + preemption ping-pong between 0 and 2
      add(4'b0101, 4, 4'b0001);
      add(4'b0101, 4, 4'b0100);
      add(4'b0101, 4, 4'b0001);
      add(4'b0101, 4, 4'b0100);
      add(4'b0000, 1, 4'b0000);
      // early release and re-grant of requester 1
      add(4'b0010, 2, 4'b0010);
      add(4'b0000, 1, 4'b0000);
      add(4'b0010, 1, 4'b0010);
      add(4'b0000, 1, 4'b0000);
      // requester 3 holds long, then preempted immediately
      add(4'b1000, 20, 4'b1000);
      add(4'b1001, 4, 4'b0001);
      add(4'b1001, 1, 4'b1000);
      add(4'b0000, 1, 4'b0000);
      // full round robin, twice around
      for (int r = 0; r < 2; r++) begin
         add(4'b1111, 4, 4'b0001);
         add(4'b1111, 4, 4'b0010);
         add(4'b1111, 4, 4'b0100);
         add(4'b1111, 4, 4'b1000);
      end
      // release handoff, then owner drops exactly at hold expiry
      add(4'b0101, 4, 4'b0001);
      add(4'b0100, 4, 4'b0100);
      add(4'b0011, 1, 4'b0001);
      add(4'b0000, 1, 4'b0000);
      // a brief non-owner pulse during hold is forgotten
      add(4'b0010, 1, 4'b0010);
      add(4'b0011, 1, 4'b0010);
      add(4'b0010, 3, 4'b0010);
      add(4'b0000, 1, 4'b0000);

      repeat (3) @(posedge clk5);
      #1;
      chk("reset grant", 32'(grant), 32'h0);
      chk("reset dispVal", 32'(dispVal), 32'h0);
      chk("reset point", 32'(point), 32'h0);
      chk("reset busy", 32'(busy), 32'h0);
      @(negedge clk5);
      resetn = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk5);
         req = vecs[i].req;
         sb.push_back(mk(vecs[i].grant, i));
         @(posedge clk5);
         #1;
         if (sb.size() == 0) chk("scoreboard empty", 32'h0, 32'h1);
         else begin
            e = sb.pop_front();
            check_out(e);
         end
      end

      // value and point changes reach the display one edge later
      @(negedge clk5);
      req = 4'b0010;
      @(posedge clk5);
      #1;
      chk("dp grant", 32'(grant), 32'h2);
      chk("dp initial", 32'(dispVal), 32'h2222);
      @(negedge clk5);
      reqVal[31:16]  = 16'hBEEF;
      reqPoint[7:4]  = 4'h6;
      #1;
      chk("dp before edge", 32'(dispVal), 32'h2222);
      @(posedge clk5);
      #1;
      chk("dp value change", 32'(dispVal), 32'hBEEF);
      chk("dp point change", 32'(point), 32'h6);

      // async reset mid-ownership, no clock edge in between
      @(posedge clk5);
      #2;
      resetn = 1'b0;
      #1;
      chk("async grant", 32'(grant), 32'h0);
      chk("async dispVal", 32'(dispVal), 32'h0);
      chk("async point", 32'(point), 32'h0);
      chk("async busy", 32'(busy), 32'h0);

      // pointer returns to 3, so requester 0 beats 2 after reset
      @(negedge clk5);
      resetn = 1'b1;
      req = 4'b0101;
      @(posedge clk5);
      #1;
      chk("post-reset grant", 32'(grant), 32'h1);
      chk("post-reset dispVal", 32'(dispVal), 32'h1111);
      chk("post-reset busy", 32'(busy), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
